// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode values, FSM
// state encoding and the opcode legality check.
package alu_pkg;

    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_ONES = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_XNOR = 4'd8;
    localparam logic [3:0] OP_GT   = 4'd9;
    localparam logic [3:0] OP_LT   = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Legal opcodes form one contiguous range, MOV through EQ.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op >= OP_MOV) && (op <= OP_EQ);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered preference
// pointer that flips to the other port after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic ptr_q, ptr_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = ptr_q;
        ptr_d  = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt_id = 1'b0;
                2'b10:   gnt_id = 1'b1;
                default: gnt_id = ptr_q;
            endcase
            if (|req) begin
                gnt   = gnt_id ? 2'b10 : 2'b01;
                ptr_d = ~gnt_id;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; reset here is synchronous, checked inside the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler feeding the shared 8-bit ALU from two requesters.
// Optional build macro ALU_OP_TRAP_EN: illegal opcodes bypass the ALU and flag rsp_err.
module alu_req_sched
    import alu_pkg::*;
#(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DW-1:0]   req_a,
    input  logic [2*DW-1:0]   req_b,
    input  logic [2*OPW-1:0]  req_op,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [OPW-1:0]    alu_ctrl,
    input  logic [DW-1:0]     alu_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_id,
    output logic              rsp_err
);

    state_e          state_q, state_d;
    logic            id_q, id_d;
    logic [DW-1:0]   alu_a_q, alu_a_d;
    logic [DW-1:0]   alu_b_q, alu_b_d;
    logic [OPW-1:0]  alu_ctrl_q, alu_ctrl_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_id_q, rsp_id_d;
`ifdef ALU_OP_TRAP_EN
    logic            rsp_err_q, rsp_err_d;
`endif

    logic [1:0]      gnt;
    logic            gnt_id;
    logic            arb_en;
    logic [DW-1:0]   sel_a, sel_b;
    logic [OPW-1:0]  sel_op;

    // Holding rst_n low also blocks the handshake so nothing is accepted and lost.
    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req    (req_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign sel_a  = gnt_id ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
    assign sel_b  = gnt_id ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
    assign sel_op = gnt_id ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
`ifdef ALU_OP_TRAP_EN
        rsp_err_d  = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d = gnt_id;
`ifdef ALU_OP_TRAP_EN
                    if (!is_legal_op(sel_op)) begin
                        rsp_data_d = '0;
                        rsp_id_d   = gnt_id;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_ctrl_d = sel_op;
                        state_d    = ISSUE;
                    end
`else
                    alu_a_d    = sel_a;
                    alu_b_d    = sel_b;
                    alu_ctrl_d = sel_op;
                    state_d    = ISSUE;
`endif
                end
            end
            ISSUE: begin
                rsp_data_d = alu_s;
                rsp_id_d   = id_q;
`ifdef ALU_OP_TRAP_EN
                rsp_err_d  = 1'b0;
`endif
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
`ifdef ALU_OP_TRAP_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
`ifdef ALU_OP_TRAP_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign req_ready = gnt;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
`ifdef ALU_OP_TRAP_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// Self-checking bench for alu_req_sched: transaction-level reference model,
// directed literal cases, then randomized traffic with occasional resets.
module tb_alu_req_sched;
    import alu_pkg::*;

    localparam int DW  = 8;
    localparam int OPW = 4;
`ifdef ALU_OP_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [2*DW-1:0]   req_a = '0;
    logic [2*DW-1:0]   req_b = '0;
    logic [2*OPW-1:0]  req_op = '0;
    logic [DW-1:0]     alu_a, alu_b, alu_s;
    logic [OPW-1:0]    alu_ctrl;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DW-1:0]     rsp_data;
    logic              rsp_id, rsp_err;

    always #5 clk = ~clk;

    alu_req_sched #(.DW(DW), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_s     (alu_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    // Stand-in for the external ALU; also the reference for expected results.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        case (op)
            OP_MOV:  return a;
            OP_INC:  return a + 8'd1;
            OP_DEC:  return a - 8'd1;
            OP_ONES: return ~a;
            OP_NOR:  return ~(a | b);
            OP_XOR:  return a ^ b;
            OP_XNOR: return ~(a ^ b);
            OP_GT:   return {7'd0, a > b};
            OP_LT:   return {7'd0, a < b};
            OP_EQ:   return {7'd0, a == b};
            default: return 8'h00;
        endcase
    endfunction

    assign alu_s = alu_ref(alu_a, alu_b, alu_ctrl);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, response visible m_lat cycles
    // after acceptance, held until consumed.
    bit           m_busy = 1'b0;
    int           m_age = 0;
    int           m_lat = 2;
    logic [7:0]   m_data = 8'h00;
    logic         m_id = 1'b0;
    logic         m_err = 1'b0;
    logic         m_pref = 1'b0;
    logic [7:0]   m_alu_a = 8'h00;
    logic [7:0]   m_alu_b = 8'h00;
    logic [3:0]   m_alu_ctrl = 4'h0;
    int           cyc = 0;
    int           acc_cyc = 0;
    bit [1:0]     acc_evt = 2'b00;
    int           grant_log[$];

    function automatic logic [1:0] model_grant();
        if (!rst_n || m_busy || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return m_pref ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        logic       id;
        logic [7:0] a, b;
        logic [3:0] op;
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_pref = 1'b0;
            m_alu_a = 8'h00; m_alu_b = 8'h00; m_alu_ctrl = 4'h0;
        end else if (!m_busy) begin
            g = model_grant();
            if (g != 2'b00) begin
                id = g[1];
                a  = req_a[int'(id)*DW +: DW];
                b  = req_b[int'(id)*DW +: DW];
                op = req_op[int'(id)*OPW +: OPW];
                m_busy = 1'b1; m_age = 1; m_id = id; m_pref = ~id;
                acc_evt[id] = 1'b1; acc_cyc = cyc;
                grant_log.push_back(int'(id));
                if (TRAP && !(op >= 4'd2 && op <= 4'd11)) begin
                    m_lat = 1; m_data = 8'h00; m_err = 1'b1;
                end else begin
                    m_lat = 2; m_data = alu_ref(a, b, op); m_err = 1'b0;
                    m_alu_a = a; m_alu_b = b; m_alu_ctrl = op;
                end
            end
        end else if (m_age >= m_lat && rsp_ready) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        logic exp_v;
        exp_v = m_busy && (m_age >= m_lat);
        check("req_ready", req_ready, model_grant());
        check("req_ready_onehot", ($countones(req_ready) <= 1), 1);
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
            check("rsp_err", rsp_err, m_err);
        end
        check("alu_a", alu_a, m_alu_a);
        check("alu_b", alu_b, m_alu_b);
        check("alu_ctrl", alu_ctrl, m_alu_ctrl);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (n) tick();
        acc_evt = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        req_a[id*DW +: DW]   = a;
        req_b[id*DW +: DW]   = b;
        req_op[id*OPW +: OPW] = op;
        req_valid[id] = 1'b1;
    endtask

    // Issue one request with rsp_ready high and report what came back.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, output int lat, output logic [7:0] data,
                         output logic rid, output logic err);
        int n;
        acc_evt[id] = 1'b0;
        set_req(id, a, b, op);
        n = 0;
        while (!acc_evt[id] && n < 20) begin tick(); n++; end
        check("accept_seen", acc_evt[id], 1);
        req_valid[id] = 1'b0;
        acc_evt[id] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        check("rsp_seen", rsp_valid, 1);
        lat  = cyc - acc_cyc + 1;
        data = rsp_data;
        rid  = rsp_id;
        err  = rsp_err;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((req_valid != 2'b00 || m_busy) && n < 60) begin
            for (int i = 0; i < 2; i++) begin
                if (acc_evt[i]) begin req_valid[i] = 1'b0; acc_evt[i] = 1'b0; end
            end
            tick();
            n++;
        end
        rsp_ready = 1'b1;
        check("drain_done", (req_valid == 2'b00) && !m_busy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] d;
        logic       rid, err;
        logic [7:0] held;
        int         n, vcount;

        do_reset(2);
        @(negedge clk);
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_alu_a", alu_a, 8'h00);
        check("reset_rsp_data", rsp_data, 8'h00);
        tick();

        issue(0, 8'hFF, 8'h00, OP_INC, lat, d, rid, err);
        check("inc_ff_data", d, 8'h00);
        check("inc_ff_lat", lat, 2);
        check("inc_ff_id", rid, 0);
        issue(1, 8'd5, 8'd3, OP_GT, lat, d, rid, err);
        check("gt_5_3", d, 8'h01);
        check("gt_id", rid, 1);
        issue(1, 8'h3C, 8'h3C, OP_EQ, lat, d, rid, err);
        check("eq_3c", d, 8'h01);
        issue(1, 8'd5, 8'd3, OP_LT, lat, d, rid, err);
        check("lt_5_3", d, 8'h00);
        issue(0, 8'h0F, 8'h3C, OP_XOR, lat, d, rid, err);
        check("xor_0f_3c", d, 8'h33);

        // Both requesters continuously valid straight out of reset.
        do_reset(1);
        grant_log.delete();
        set_req(0, 8'h01, 8'h02, OP_MOV);
        set_req(1, 8'h03, 8'h04, OP_MOV);
        n = 0;
        while (grant_log.size() < 4 && n < 60) begin
            for (int i = 0; i < 2; i++) begin
                if (acc_evt[i]) begin
                    acc_evt[i] = 1'b0;
                    set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(2, 11)));
                end
            end
            tick();
            n++;
        end
        check("rr_grant_count", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            check("rr_grant0", grant_log[0], 0);
            check("rr_grant1", grant_log[1], 1);
            check("rr_grant2", grant_log[2], 0);
            check("rr_grant3", grant_log[3], 1);
        end
        drain();

        // Consumer stall while the other port waits.
        rsp_ready = 1'b0;
        acc_evt = 2'b00;
        set_req(0, 8'hA5, 8'h00, OP_MOV);
        n = 0;
        while (!acc_evt[0] && n < 20) begin tick(); n++; end
        req_valid[0] = 1'b0;
        acc_evt[0] = 1'b0;
        set_req(1, 8'h77, 8'h11, OP_NOR);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        held = rsp_data;
        check("stall_first_data", held, 8'hA5);
        repeat (4) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, 8'hA5);
            check("stall_id", rsp_id, 0);
            check("stall_no_ready", req_ready, 2'b00);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("release_idle_valid", rsp_valid, 0);
        check("release_grant", req_ready, 2'b10);
        drain();

        // Reset while an operation sits in ISSUE.
        acc_evt = 2'b00;
        set_req(0, 8'h10, 8'h00, OP_INC);
        n = 0;
        while (!acc_evt[0] && n < 20) begin tick(); n++; end
        acc_evt[0] = 1'b0;
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_issue_req_ready", req_ready, 2'b00);
        check("rst_issue_rsp_valid", rsp_valid, 0);
        check("rst_issue_alu_a", alu_a, 8'h00);
        check("rst_issue_alu_ctrl", alu_ctrl, 4'h0);
        check("rst_issue_rsp_data", rsp_data, 8'h00);
        check("rst_issue_rsp_id", rsp_id, 0);
        check("rst_issue_rsp_err", rsp_err, 0);
        vcount = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid) vcount++; end
        check("rst_issue_no_rsp", vcount, 0);
        tick();
        set_req(0, 8'h21, 8'h00, OP_MOV);
        set_req(1, 8'h22, 8'h00, OP_MOV);
        @(negedge clk);
        check("rst_ptr_grant", req_ready, 2'b01);
        tick();
        drain();

        // Illegal opcode 13.
        issue(0, 8'h55, 8'h00, 4'd13, lat, d, rid, err);
        check("illegal_data", d, 8'h00);
        check("illegal_err", err, TRAP);
        check("illegal_lat", lat, TRAP ? 1 : 2);

        // Randomized traffic with random backpressure and rare resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc_evt[i]) begin req_valid[i] = 1'b0; acc_evt[i] = 1'b0; end
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            if (!rst_n) begin
                req_valid = 2'b00;
                acc_evt = 2'b00;
            end
            tick();
        end
        rst_n = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
